scan_xchg_engine: RTL and testbench

On-chip scan-exchange sequencer for one or more qtcore-style scan chains; turns the bench-side scan, reset and run procedures into a command-driven hardware engine. Accepts one command at a time over a valid/ready handshake: processor reset, full-chain exchange (parallel load → serial shift → parallel unload), or a bounded run-until-halt. Sits between a host interface (SPI/UART bridge or test controller) and the processor tiles, sharing their clock.

---
 rtl/scan_xchg_pkg.sv | 27 ++
 rtl/scan_shift_reg.sv | 54 +++++
 rtl/scan_xchg_engine.sv | 199 +++++++++++++++++++
 tb/tb_scan_xchg_engine.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_xchg_pkg.sv
// scan_xchg_pkg
// Shared definitions for the scan-exchange engine: command opcodes, the
// sequencer state encoding and default timing constants.
package scan_xchg_pkg;

   // Default number of RUN cycles before a halt flag is honoured.
   localparam int MIN_RUN_DEF    = 4;
   // Default length of the processor reset pulse, in clock cycles.
   localparam int RST_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      OP_RESET = 2'd0,
      OP_XCHG  = 2'd1,
      OP_RUN   = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RESET = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_RUN   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// scan_shift_reg
// Parallel-load / serial-shift / capture register for one scan-chain image.
// The MSB is presented to the chain first; the bit returned by the chain is
// appended at the LSB, so after CHAIN_LEN shifts the register holds the
// chain's previous contents in the same bit order as the loaded image.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          load load_data and clear the bit counter
//   load_data     image to be shifted out
//   shift         advance one bit, capturing capture_bit
//   capture_bit   serial bit returned by the chain
//   msb           bit currently driven towards the chain
//   last_bit      high while the final bit of the image is being shifted
//   shifted       register value after the shift in progress
module scan_shift_reg
   import scan_xchg_pkg::*;
#(
   parameter int CHAIN_LEN = 160
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CHAIN_LEN-1:0] load_data,
   input  logic                 shift,
   input  logic                 capture_bit,
   output logic                 msb,
   output logic                 last_bit,
   output logic [CHAIN_LEN-1:0] shifted
);

   localparam int               CNT_W    = $clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

   logic [CHAIN_LEN-1:0] sr_reg;
   logic [CNT_W-1:0]     bit_cnt_reg;

   assign shifted  = {sr_reg[CHAIN_LEN-2:0], capture_bit};
   assign msb      = sr_reg[CHAIN_LEN-1];
   assign last_bit = (bit_cnt_reg == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_reg      <= '0;
         bit_cnt_reg <= '0;
      end else if (load) begin
         sr_reg      <= load_data;
         bit_cnt_reg <= '0;
      end else if (shift) begin
         sr_reg      <= shifted;
         bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/scan_xchg_engine.sv
// scan_xchg_engine
// Command-driven sequencer for processor scan chains. One command at a time
// is accepted over cmd_valid_in/cmd_ready_out:
//   RESET - pulse proc_rst_out of the target chain for RST_CYCLES cycles
//   XCHG  - shift load_data_in into the chain while capturing its old image
//   RUN   - enable the processor until the cycle limit or its halt flag
// Every command ends with a one-cycle done_out pulse. Non-selected chains see
// all controls held low. Invalid chains and the reserved opcode complete as
// no-ops.
// Ports:
//   clk_in, rst_in             clock, asynchronous active-high reset
//   cmd_*                      command handshake and operands
//   load_data_in               XCHG image (MSB shifted first)
//   unload_data_out            image captured by the last XCHG
//   done_out                   completion pulse
//   halted_out, cycles_out     result of the last RUN
//   proc_rst_out, scan_en_out, proc_en_out, scan_data_out   per-chain controls
//   scan_data_in               chain scan output / halt flag when not scanning
// Optional feature (macro SCAN_XCHG_VERIFY_EN): expect_data_in, expect_mask_in
// and mismatch_out compare the unloaded image against an expected image.
module scan_xchg_engine
   import scan_xchg_pkg::*;
#(
   parameter int  CHAIN_LEN  = 160,
   parameter int  NUM_CHAINS = 2,
   parameter int  CYC_W      = 16,
   parameter int  MIN_RUN    = MIN_RUN_DEF,
   parameter int  RST_CYCLES = RST_CYCLES_DEF,
   localparam int CH_W       = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  cmd_valid_in,
   output logic                  cmd_ready_out,
   input  logic [1:0]            cmd_op_in,
   input  logic [CH_W-1:0]       cmd_chain_in,
   input  logic [CYC_W-1:0]      cmd_cycles_in,
   input  logic [CHAIN_LEN-1:0]  load_data_in,
`ifdef SCAN_XCHG_VERIFY_EN
   input  logic [CHAIN_LEN-1:0]  expect_data_in,
   input  logic [CHAIN_LEN-1:0]  expect_mask_in,
   output logic                  mismatch_out,
`endif
   output logic [CHAIN_LEN-1:0]  unload_data_out,
   output logic                  done_out,
   output logic                  halted_out,
   output logic [CYC_W-1:0]      cycles_out,
   output logic [NUM_CHAINS-1:0] proc_rst_out,
   output logic [NUM_CHAINS-1:0] scan_en_out,
   output logic [NUM_CHAINS-1:0] proc_en_out,
   output logic [NUM_CHAINS-1:0] scan_data_out,
   input  logic [NUM_CHAINS-1:0] scan_data_in
);

   localparam int               RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] MIN_RUN_C = CYC_W'(MIN_RUN);

   state_e                  state_reg, state_next;
   logic                    ready_reg, done_reg, halted_reg;
   logic [NUM_CHAINS-1:0]   sel_reg, sel_next, cmd_sel;
   logic [CYC_W-1:0]        limit_reg, run_cnt_reg, cycles_reg, run_cnt_inc;
   logic [RC_W-1:0]         rst_cnt_reg;
   logic [CHAIN_LEN-1:0]    unload_reg, shifted;
   logic [NUM_CHAINS-1:0]   proc_rst_reg, scan_en_reg, proc_en_reg;
   logic                    accept, cmd_ok, sel_in, halt_ok, run_exit;
   logic                    sr_msb, last_bit;
`ifdef SCAN_XCHG_VERIFY_EN
   logic                    mismatch_reg;
`endif

   // One-hot decode of the requested chain; all-zero means out of range.
   for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_sel
      assign cmd_sel[gi] = (cmd_chain_in == CH_W'(gi));
   end

   assign accept   = cmd_valid_in & ready_reg;
   assign cmd_ok   = |cmd_sel;
   assign sel_next = accept ? cmd_sel : sel_reg;

   // Selected chain's return bit: scan data while shifting, halt flag otherwise.
   assign sel_in      = |(scan_data_in & sel_reg);
   assign run_cnt_inc = run_cnt_reg + 1'b1;
   assign halt_ok     = sel_in && (run_cnt_inc >= MIN_RUN_C);
   assign run_exit    = (run_cnt_inc == limit_reg) || halt_ok;

   scan_shift_reg #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_shift (
      .clk         (clk_in),
      .rst         (rst_in),
      .load        (accept && cmd_ok && (cmd_op_in == OP_XCHG)),
      .load_data   (load_data_in),
      .shift       (state_reg == ST_SHIFT),
      .capture_bit (sel_in),
      .msb         (sr_msb),
      .last_bit    (last_bit),
      .shifted     (shifted)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (!cmd_ok) begin
                  state_next = ST_DONE;
               end else begin
                  case (cmd_op_in)
                     OP_RESET: state_next = ST_RESET;
                     OP_XCHG:  state_next = ST_SHIFT;
                     OP_RUN:   state_next = (cmd_cycles_in == '0) ? ST_DONE : ST_RUN;
                     default:  state_next = ST_DONE;
                  endcase
               end
            end
         end
         ST_RESET: if (rst_cnt_reg == RST_LAST) state_next = ST_GAP;
         ST_SHIFT: if (last_bit) state_next = ST_GAP;
         ST_RUN:   if (run_exit) state_next = ST_GAP;
         ST_GAP:   state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg    <= ST_IDLE;
         ready_reg    <= 1'b1;
         done_reg     <= 1'b0;
         halted_reg   <= 1'b0;
         sel_reg      <= '0;
         limit_reg    <= '0;
         run_cnt_reg  <= '0;
         cycles_reg   <= '0;
         rst_cnt_reg  <= '0;
         unload_reg   <= '0;
         proc_rst_reg <= '0;
         scan_en_reg  <= '0;
         proc_en_reg  <= '0;
`ifdef SCAN_XCHG_VERIFY_EN
         mismatch_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next == ST_IDLE);
         done_reg  <= (state_next == ST_DONE);
         sel_reg   <= sel_next;

         if (accept) begin
            limit_reg   <= cmd_cycles_in;
            run_cnt_reg <= '0;
            rst_cnt_reg <= '0;
            // A zero-length RUN still reports its (empty) result.
            if (cmd_ok && (cmd_op_in == OP_RUN) && (cmd_cycles_in == '0)) begin
               cycles_reg <= '0;
               halted_reg <= 1'b0;
            end
         end

         if (state_reg == ST_RESET) rst_cnt_reg <= rst_cnt_reg + 1'b1;

         if (state_reg == ST_RUN) begin
            run_cnt_reg <= run_cnt_inc;
            if (run_exit) begin
               cycles_reg <= run_cnt_inc;
               halted_reg <= halt_ok;
            end
         end

         if ((state_reg == ST_SHIFT) && last_bit) begin
            unload_reg <= shifted;
`ifdef SCAN_XCHG_VERIFY_EN
            mismatch_reg <= |((shifted ^ expect_data_in) & expect_mask_in);
`endif
         end

         // Controls are registered from the next state so they track it exactly.
         proc_rst_reg <= (state_next == ST_RESET) ? sel_next : '0;
         scan_en_reg  <= (state_next == ST_SHIFT) ? sel_next : '0;
         proc_en_reg  <= (state_next == ST_RUN)   ? sel_next : '0;
      end
   end

   assign cmd_ready_out   = ready_reg;
   assign done_out        = done_reg;
   assign halted_out      = halted_reg;
   assign cycles_out      = cycles_reg;
   assign unload_data_out = unload_reg;
   assign proc_rst_out    = proc_rst_reg;
   assign scan_en_out     = scan_en_reg;
   assign proc_en_out     = proc_en_reg;
   assign scan_data_out   = scan_en_reg & {NUM_CHAINS{sr_msb}};
`ifdef SCAN_XCHG_VERIFY_EN
   assign mismatch_out    = mismatch_reg;
`endif

endmodule

// File: tb/tb_scan_xchg_engine.sv
// tb_scan_xchg_engine
// Directed bench for scan_xchg_engine. Each chain is modelled as a plain
// shift register; when not scanning, a chain returns a halt flag that rises
// after a programmed number of enabled cycles. Build with
// SCAN_XCHG_VERIFY_EN defined to also exercise the compare outputs.
module tb_scan_xchg_engine;

   localparam int L      = 160;
   localparam int NCH    = 3;
   localparam int CW     = 16;
   localparam int CH_W   = 2;
   localparam int NOHALT = 100000;

   localparam logic [L-1:0] C0    = {5{32'hDEAD_BEEF}};
   localparam logic [L-1:0] C1    = {5{32'h0BAD_F00D}};
   localparam logic [L-1:0] C2    = {5{32'h5555_AAAA}};
   localparam logic [L-1:0] PAT_A = {5{32'hA5C3_0F01}};
   localparam logic [L-1:0] PAT_B = {5{32'h1234_5678}};
   localparam logic [L-1:0] PAT_D = {5{32'hCAFE_0001}};

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cmd_valid = 1'b0;
   logic [1:0]      cmd_op = '0;
   logic [CH_W-1:0] cmd_chain = '0;
   logic [CW-1:0]   cmd_cycles = '0;
   logic [L-1:0]    load_data = '0;
   logic            ready, done, halted;
   logic [CW-1:0]   cycles;
   logic [L-1:0]    unload;
   logic [NCH-1:0]  proc_rst, scan_en, proc_en, scan_do, scan_di;
`ifdef SCAN_XCHG_VERIFY_EN
   logic [L-1:0]    exp_data = '0;
   logic [L-1:0]    exp_mask = '0;
   logic            mismatch;
`endif

   always #5 clk = ~clk;

   scan_xchg_engine #(
      .CHAIN_LEN (L), .NUM_CHAINS (NCH), .CYC_W (CW), .MIN_RUN (4), .RST_CYCLES (2)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .cmd_valid_in    (cmd_valid),
      .cmd_ready_out   (ready),
      .cmd_op_in       (cmd_op),
      .cmd_chain_in    (cmd_chain),
      .cmd_cycles_in   (cmd_cycles),
      .load_data_in    (load_data),
`ifdef SCAN_XCHG_VERIFY_EN
      .expect_data_in  (exp_data),
      .expect_mask_in  (exp_mask),
      .mismatch_out    (mismatch),
`endif
      .unload_data_out (unload),
      .done_out        (done),
      .halted_out      (halted),
      .cycles_out      (cycles),
      .proc_rst_out    (proc_rst),
      .scan_en_out     (scan_en),
      .proc_en_out     (proc_en),
      .scan_data_out   (scan_do),
      .scan_data_in    (scan_di)
   );

   // ---------------- chain / processor environment model ----------------
   logic          tb_init = 1'b1;
   logic [L-1:0]  chain_init [NCH];
   logic [L-1:0]  chain [NCH];
   int unsigned   se_cnt [NCH];
   int unsigned   pr_cnt [NCH];
   int unsigned   pe_cnt [NCH];
   int unsigned   pe_base [NCH];
   int unsigned   halt_at [NCH];
   int unsigned   done_cnt = 0;

   always @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (tb_init) begin
            chain[i]  <= chain_init[i];
            se_cnt[i] <= 0;
            pr_cnt[i] <= 0;
            pe_cnt[i] <= 0;
         end else begin
            if (scan_en[i]) begin
               chain[i]  <= {chain[i][L-2:0], scan_do[i]};
               se_cnt[i] <= se_cnt[i] + 1;
            end
            if (proc_rst[i]) pr_cnt[i] <= pr_cnt[i] + 1;
            if (proc_en[i])  pe_cnt[i] <= pe_cnt[i] + 1;
         end
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   always_comb begin
      scan_di = '0;
      for (int i = 0; i < NCH; i++)
         scan_di[i] = scan_en[i] ? chain[i][L-1] : ((pe_cnt[i] - pe_base[i]) >= halt_at[i]);
   end

   // ---------------- checking ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int guard = 0;
      @(negedge clk);
      while (ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("ready_wait", {31'd0, ready}, 1);
   endtask

   // Issue one command; lat is the cycle (counting the accept cycle as 0) in
   // which done_out is seen. Also checks that done is a single-cycle pulse.
   task automatic issue(input logic [1:0] op, input logic [CH_W-1:0] ch,
                        input logic [CW-1:0] cyc, input logic [L-1:0] img, output int lat);
      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_chain = ch; cmd_cycles = cyc; load_data = img;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("[TB] txn op=%0d chain=%0d cycles_in=%0d latency=%0d cycles_out=%0d halted=%0d unload=%h",
               op, ch, cyc, lat, cycles, halted, unload);
      @(posedge clk); #1;
      check("done_pulse", {31'd0, done}, 0);
   endtask

   function automatic logic [L-1:0] diff(input int unsigned a, input int unsigned b);
      return L'(a - b);
   endfunction

   initial begin
      int           lat, g;
      int unsigned  b0, b1, b2, d0;
      logic [L-1:0] prev, img, part;

      chain_init[0] = C0; chain_init[1] = C1; chain_init[2] = C2;
      for (int i = 0; i < NCH; i++) begin
         halt_at[i] = NOHALT;
         pe_base[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      tb_init = 1'b0;

      // Reset values
      check("rst_ready",    {31'd0, ready}, 1);
      check("rst_done",     {31'd0, done}, 0);
      check("rst_halted",   {31'd0, halted}, 0);
      check("rst_cycles",   cycles, 0);
      check("rst_unload",   unload, 0);
      check("rst_controls", {proc_rst, scan_en, proc_en, scan_do}, 0);
      rst = 1'b0;

      // RESET chain 0
      b0 = pr_cnt[0]; b1 = pr_cnt[1]; b2 = pr_cnt[2];
      issue(2'd0, 2'd0, 16'd0, '0, lat);
      check("reset_lat",     lat, 4);
      check("reset_pr0",     diff(pr_cnt[0], b0), 2);
      check("reset_pr_oth",  diff(pr_cnt[1] + pr_cnt[2], b1 + b2), 0);

      // XCHG chain 0 with PAT_A: unload old chain content C0
      b0 = se_cnt[0]; b1 = se_cnt[1];
      issue(2'd1, 2'd0, 16'd0, PAT_A, lat);
      check("xchg0_lat",    lat, L + 2);
      check("xchg0_unload", unload, C0);
      check("xchg0_chain",  chain[0], PAT_A);
      check("xchg0_se0",    diff(se_cnt[0], b0), L);
      check("xchg0_se1",    diff(se_cnt[1], b1), 0);

      // XCHG chain 1, chain 0 untouched
      issue(2'd1, 2'd1, 16'd0, PAT_D, lat);
      check("xchg1_unload", unload, C1);
      check("xchg1_chain",  chain[1], PAT_D);
      check("xchg1_ch0",    chain[0], PAT_A);

      // Second XCHG on chain 0 returns the first image
      issue(2'd1, 2'd0, 16'd0, PAT_B, lat);
      check("xchg2_unload", unload, PAT_A);

      // RUN chain 0, limit 8, no halt
      b0 = pe_cnt[0]; b1 = pe_cnt[1];
      issue(2'd2, 2'd0, 16'd8, '0, lat);
      check("run8_lat",    lat, 10);
      check("run8_cycles", cycles, 8);
      check("run8_halted", {31'd0, halted}, 0);
      check("run8_pe0",    diff(pe_cnt[0], b0), 8);
      check("run8_pe1",    diff(pe_cnt[1], b1), 0);

      // RUN chain 1, halt after 6 enabled cycles: exits on cycle 7
      pe_base[1] = pe_cnt[1]; halt_at[1] = 6;
      issue(2'd2, 2'd1, 16'd256, '0, lat);
      check("runh_lat",    lat, 9);
      check("runh_cycles", cycles, 7);
      check("runh_halted", {31'd0, halted}, 1);

      // Halt and limit coincide: halted wins
      pe_base[1] = pe_cnt[1];
      issue(2'd2, 2'd1, 16'd7, '0, lat);
      check("runhl_cycles", cycles, 7);
      check("runhl_halted", {31'd0, halted}, 1);
      halt_at[1] = NOHALT;

      // Halt high from the start, limit below MIN_RUN: limit exit
      pe_base[0] = pe_cnt[0]; halt_at[0] = 0;
      issue(2'd2, 2'd0, 16'd2, '0, lat);
      check("runmin_lat",    lat, 4);
      check("runmin_cycles", cycles, 2);
      check("runmin_halted", {31'd0, halted}, 0);

      // Halt high from the start: honoured only at MIN_RUN
      pe_base[0] = pe_cnt[0];
      issue(2'd2, 2'd0, 16'd256, '0, lat);
      check("runh0_lat",    lat, 6);
      check("runh0_cycles", cycles, 4);
      check("runh0_halted", {31'd0, halted}, 1);
      halt_at[0] = NOHALT;

      // Zero-cycle RUN
      b0 = pe_cnt[0];
      issue(2'd2, 2'd0, 16'd0, '0, lat);
      check("run0_lat",    lat, 1);
      check("run0_cycles", cycles, 0);
      check("run0_halted", {31'd0, halted}, 0);
      check("run0_pe",     diff(pe_cnt[0], b0), 0);

      // Invalid chain and reserved opcode: no-ops, results unchanged
      issue(2'd2, 2'd0, 16'd5, '0, lat);
      b0 = pe_cnt[0] + pe_cnt[1] + pe_cnt[2];
      d0 = se_cnt[0] + se_cnt[1] + se_cnt[2];
      issue(2'd2, 2'd3, 16'd9, '0, lat);
      check("badch_run_lat",    lat, 1);
      check("badch_run_cycles", cycles, 5);
      issue(2'd1, 2'd3, 16'd0, PAT_D, lat);
      check("badch_xchg_lat",   lat, 1);
      check("badch_xchg_unld",  unload, PAT_A);
      issue(2'd3, 2'd0, 16'd0, PAT_D, lat);
      check("rsvd_lat",         lat, 1);
      check("rsvd_unload",      unload, PAT_A);
      check("noop_pe",          diff(pe_cnt[0] + pe_cnt[1] + pe_cnt[2], b0), 0);
      check("noop_se",          diff(se_cnt[0] + se_cnt[1] + se_cnt[2], d0), 0);

      // Commands offered while busy are ignored
      b0 = se_cnt[0]; d0 = done_cnt;
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_chain = 2'd0; cmd_cycles = 16'd12;
      @(posedge clk); #1;
      cmd_op = 2'd1; load_data = PAT_D;
      for (int i = 0; i < 5; i++) begin
         check("busy_ready", {31'd0, ready}, 0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      g = 0;
      while (done !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] txn busy RUN cycles_out=%0d done_pulses=%0d", cycles, done_cnt - d0);
      check("busy_cycles", cycles, 12);
      check("busy_dones",  diff(done_cnt, d0), 1);
      check("busy_se0",    diff(se_cnt[0], b0), 0);

      // rst_in after 80 shifted bits
      prev = chain[0];
      img  = C0;
      b0   = se_cnt[0];
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_chain = 2'd0; load_data = img;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      g = 0;
      while ((se_cnt[0] - b0) < 80 && g < 500) begin @(posedge clk); #1; g++; end
      rst = 1'b1;
      #1;
      d0 = done_cnt;
      $display("[TB] txn rst_in at shift bit %0d", se_cnt[0] - b0);
      check("mid_bits",     diff(se_cnt[0], b0), 80);
      check("mid_ready",    {31'd0, ready}, 1);
      check("mid_outs",     {done, halted, proc_rst, scan_en, proc_en, scan_do}, 0);
      check("mid_cycles",   cycles, 0);
      check("mid_unload",   unload, 0);
`ifdef SCAN_XCHG_VERIFY_EN
      check("mid_mismatch", {31'd0, mismatch}, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_no_done",  diff(done_cnt, d0), 0);
      part = {prev[79:0], img[159:80]};
      issue(2'd1, 2'd0, 16'd0, PAT_A, lat);
      check("post_lat",     lat, L + 2);
      check("post_unload",  unload, part);
      check("post_chain",   chain[0], PAT_A);

`ifdef SCAN_XCHG_VERIFY_EN
      img = PAT_B;
      img[37] = ~img[37];
      exp_mask = '1;
      exp_data = PAT_A;
      issue(2'd1, 2'd0, 16'd0, PAT_B, lat);
      check("vfy_match",    {31'd0, mismatch}, 0);
      exp_data = img;
      issue(2'd1, 2'd0, 16'd0, PAT_A, lat);
      check("vfy_flip",     {31'd0, mismatch}, 1);
      exp_data = PAT_A;
      exp_data[37] = ~exp_data[37];
      exp_mask[37] = 1'b0;
      issue(2'd1, 2'd0, 16'd0, PAT_B, lat);
      check("vfy_masked",   {31'd0, mismatch}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
